triangle_sweep_controller: RTL and testbench
============================================

// Module: triangle_sweep_controller
// PURPOSE
//  Sequencer for one N-bit triangle_generator in the etch-a-sketch datapath.
//  On a start request it releases the generator from reset and drives its enable
//  at a programmable rate. It runs a programmable number of full triangle periods,
//  then parks the generator in reset again. Reports busy, per-period ticks and done.
// PARAMETERS
//  N           4  bit width of the controlled generator; one period = STEPS = 2^(N+1)-2 enables
//  PRESCALE_W  8  width of prescale input
//  CYCLES_W    8  width of n_periods / periods_done
// PORTS
//  clk           in   1           system clock
//  rst           in   1           synchronous reset, active-high
//  start         in   1           request a sweep; sampled only in IDLE
//  prescale      in   PRESCALE_W  enable every prescale+1 clocks; latched at start
//  n_periods     in   CYCLES_W    periods to run; 0 = continuous until abort; latched at start
//  abort         in   1           stop sweep; effective only in RUN
//  tri_rst       out  1           reset to triangle_generator
//  tri_ena       out  1           enable to triangle_generator
//  busy          out  1           high while in RUN
//  period_tick   out  1           1-cycle pulse after each completed period
//  done          out  1           1-cycle pulse when the requested count completes
//  periods_done  out  CYCLES_W    completed periods of current/last sweep
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. Reset -> IDLE; outputs: tri_rst=1, all others 0.
//  - IDLE: tri_rst=1. start=1 at an edge: latch prescale->p_lat, n_periods->n_lat;
//    clear pc, sc and periods_done; go RUN.
//  - RUN: tri_rst=0, busy=1. pc counts 0..p_lat, then wraps to 0.
//    tri_ena = RUN && pc==p_lat, decoded from registers. First enable falls
//    p_lat+1 cycles after RUN is entered. p_lat=0 gives an enable every cycle.
//  - sc counts sampled enables 0..STEPS-1. An enable with sc==STEPS-1 sets
//    sc->0 and period_tick=1 next cycle. periods_done then increments and
//    saturates at all-ones.
//  - If n_lat!=0 and periods_done+1==n_lat on that wrap -> go DONE.
//  - DONE (exactly 1 cycle): done=1, busy=0, tri_rst=1, tri_ena=0 -> IDLE.
//  - abort in RUN -> IDLE next edge: no done, no period_tick.
//    periods_done holds its value.
//  - abort beats a same-edge period completion.
//  - start and abort outside IDLE/RUN as applicable are ignored; start while
//    busy has no effect.
//  - n_periods=0: runs until abort; periods_done saturates and stays at max.
//  - periods_done holds after DONE/abort until the next accepted start.
//  - rst at any time (mid-RUN included) -> reset values at that edge; ignores
//    start and abort.
//  - All arithmetic unsigned. pc is PRESCALE_W bits. sc is N+1 bits.
// STRUCTURE
//  - Package triangle_sweep_pkg: typedef enum {S_IDLE,S_RUN,S_DONE} sweep_state_t;
//    function tri_steps(N) returning 2^(N+1)-2.
//  - One sub-module pulse_divider #(W): clk, rst, clr, ena, term[W-1:0] -> strobe.
//    It holds the pc counter. The FSM, sc and periods_done stay in the top level.
// TESTING  (N=4, STEPS=30; cycle k = k edges after start accepted)
//  1. prescale=0, n_periods=2 -> tri_ena high cycles 1..60; period_tick
//     at 31 and 61; done=1 and tri_rst=1 at 61; periods_done=2; busy low from 61.
//  2. prescale=3, n_periods=1 -> tri_ena only at cycles 4,8,..,120 (30 pulses);
//     done at 121; tri_ena never high two cycles in a row.
//  3. prescale=0, n_periods=0, abort at cycle 95 -> periods_done=3, no done pulse,
//     IDLE with tri_rst=1 at 96; start re-accepted at 97, periods_done cleared.
//  4. abort on the same edge as 2nd period completion (n=2) -> IDLE, no done,
//     no period_tick; start pulsed during RUN -> ignored, latched values unchanged.
//  5. rst asserted at cycle 40 of a sweep -> all outputs reset values next edge;
//     prescale/n_periods changed mid-RUN -> no effect on the running sweep.
//  6. Scoreboard: instantiate triangle_generator on tri_rst/tri_ena. Check out==0
//     at every period_tick, and peak 2^N-1 reached once per period.

Source files
------------

// File: rtl/triangle_sweep_pkg.sv
// Shared types and helpers for the triangle sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package triangle_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sweep_state_t;

  // Enables in one full triangle period of an n-bit up/down generator:
  // 2^n - 1 steps up to the peak plus 2^n - 1 steps back down to zero.
  function automatic int unsigned tri_steps(input int unsigned n);
    return (32'd1 << (n + 1)) - 32'd2;
  endfunction

endpackage

// File: rtl/triangle_sweep_controller_pulse_divider.sv
// Rate divider: strobes once every term+1 enabled clocks.
// Latency: first strobe term+1 clocks after clr drops; strobe is decoded from the counter register.
// Backpressure: none; clr holds the counter at zero, ena gates counting and the strobe.
module pulse_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ena,
  input  logic [W-1:0] term,
  output logic         strobe
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  assign strobe = ena && (cnt == term);

  // Count 0..term while enabled, wrapping back to zero on the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= (cnt == term) ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/triangle_sweep_controller.sv
// Sequences one triangle generator through a programmable number of periods.
// Latency: first tri_ena prescale+1 clocks after start is accepted; tick/done one clock after the last enable.
// Backpressure: none; start is ignored unless idle, abort only acts while running.
module triangle_sweep_controller
  import triangle_sweep_pkg::*;
#(
  parameter int N          = 4,
  parameter int PRESCALE_W = 8,
  parameter int CYCLES_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CYCLES_W-1:0]   n_periods,
  input  logic                  abort,
  output logic                  tri_rst,
  output logic                  tri_ena,
  output logic                  busy,
  output logic                  period_tick,
  output logic                  done,
  output logic [CYCLES_W-1:0]   periods_done
);

  localparam int unsigned STEPS = tri_steps(N);
  localparam logic [N:0]  SC_LAST = (N + 1)'(STEPS - 1);
  localparam logic [N:0]  SC_ONE  = (N + 1)'(1);
  localparam logic [CYCLES_W:0] PD_ONE = (CYCLES_W + 1)'(1);

  sweep_state_t          state;
  logic [PRESCALE_W-1:0] p_lat;
  logic [CYCLES_W-1:0]   n_lat;
  logic [N:0]            sc;
  logic [CYCLES_W:0]     pd_inc;
  logic                  running;

  assign running = (state == S_RUN);

  // One extra bit so the "last period" compare never aliases through a wrap.
  assign pd_inc = {1'b0, periods_done} + PD_ONE;

  pulse_divider #(.W(PRESCALE_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (!running),
    .ena    (running),
    .term   (p_lat),
    .strobe (tri_ena)
  );

  // Sweep FSM with step/period counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      p_lat        <= '0;
      n_lat        <= '0;
      sc           <= '0;
      periods_done <= '0;
      tri_rst      <= 1'b1;
      busy         <= 1'b0;
      period_tick  <= 1'b0;
      done         <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          tri_rst <= 1'b1;
          busy    <= 1'b0;
          if (start) begin
            p_lat        <= prescale;
            n_lat        <= n_periods;
            sc           <= '0;
            periods_done <= '0;
            tri_rst      <= 1'b0;
            busy         <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort wins over a period completing on the same edge.
            tri_rst <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (tri_ena) begin
            if (sc == SC_LAST) begin
              sc          <= '0;
              period_tick <= 1'b1;
              if (periods_done != '1) begin
                periods_done <= pd_inc[CYCLES_W-1:0];
              end
              if ((n_lat != '0) && (pd_inc == {1'b0, n_lat})) begin
                tri_rst <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= S_DONE;
              end
            end else begin
              sc <= sc + SC_ONE;
            end
          end
        end
        S_DONE: begin
          tri_rst <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          tri_rst <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_sweep_controller.sv
// Self-checking bench for triangle_sweep_controller with a behavioural triangle generator.
// Latency: n/a.
// Backpressure: n/a.
module tb_triangle_sweep_controller;

  localparam int N   = 4;
  localparam int MAX = (1 << N) - 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] prescale;
  logic [7:0] n_periods;
  logic       abort;
  logic       tri_rst;
  logic       tri_ena;
  logic       busy;
  logic       period_tick;
  logic       done;
  logic [7:0] periods_done;

  triangle_sweep_controller #(.N(N), .PRESCALE_W(8), .CYCLES_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .prescale     (prescale),
    .n_periods    (n_periods),
    .abort        (abort),
    .tri_rst      (tri_rst),
    .tri_ena      (tri_ena),
    .busy         (busy),
    .period_tick  (period_tick),
    .done         (done),
    .periods_done (periods_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edge counter and sweep bookkeeping shared by stimulus and monitor.
  int edge_n     = 0;
  int start_edge = 0;
  int cur_p      = 0;
  int ena_cnt    = 0;
  logic prev_ena = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Behavioural triangle generator driven by the controller.
  logic [N-1:0] gen_out;
  logic         gen_up;
  int           peaks;
  always @(posedge clk) begin
    if (tri_rst) begin
      gen_out <= '0;
      gen_up  <= 1'b1;
      peaks   <= 0;
    end else if (tri_ena) begin
      if (gen_up) begin
        gen_out <= gen_out + 1'b1;
        if (gen_out == N'(MAX - 1)) begin
          gen_up <= 1'b0;
          peaks  <= peaks + 1;
        end
      end else begin
        gen_out <= gen_out - 1'b1;
        if (gen_out == N'(1)) gen_up <= 1'b1;
      end
    end
  end

  // Scoreboard of expected tick/done events: kind 0 = period_tick, 1 = done.
  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t sb[$];

  task automatic push_ev(input int kind, input int cyc);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  // Monitor: pop the scoreboard on every tick/done, check enable cadence and generator state.
  always @(negedge clk) begin
    int  k;
    ev_t e;
    k = edge_n - start_edge + 1;
    if (period_tick) begin
      if (sb.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("tick_kind", 0, e.kind);
        chk("tick_cycle", k, e.cyc);
      end
      chk("gen_zero_at_tick", int'(gen_out), 0);
      chk("gen_peaks", peaks, int'(periods_done));
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_kind", 1, e.kind);
        chk("done_cycle", k, e.cyc);
      end
    end
    if (tri_ena) begin
      chk("ena_phase", k % (cur_p + 1), 0);
      chk("ena_back2back", int'(prev_ena && (cur_p != 0)), 0);
      ena_cnt++;
    end
    prev_ena = tri_ena;
  end

  function automatic int cyc_now();
    return edge_n - start_edge + 1;
  endfunction

  task automatic wait_to(input int k);
    int guard;
    guard = 0;
    while (cyc_now() < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("wait_timeout", cyc_now(), k);
  endtask

  // Drive a start request; returns at the negedge of cycle 1.
  task automatic run_start(input int p, input int n);
    prescale  = 8'(p);
    n_periods = 8'(n);
    cur_p     = p;
    ena_cnt   = 0;
    start     = 1'b1;
    start_edge = edge_n + 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("trirst_after_start", int'(tri_rst), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; prescale = '0; n_periods = '0;
    repeat (3) @(negedge clk);
    chk("rst_tri_rst", int'(tri_rst), 1);
    chk("rst_tri_ena", int'(tri_ena), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pdone", int'(periods_done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: prescale 0, two periods.
    push_ev(0, 31); push_ev(0, 61); push_ev(1, 61);
    run_start(0, 2);
    wait_to(61);
    chk("t1_done", int'(done), 1);
    chk("t1_busy", int'(busy), 0);
    chk("t1_tri_rst", int'(tri_rst), 1);
    wait_to(64);
    chk("t1_pdone", int'(periods_done), 2);
    chk("t1_ena_cnt", ena_cnt, 60);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: prescale 3, one period.
    push_ev(0, 121); push_ev(1, 121);
    run_start(3, 1);
    wait_to(121);
    chk("t2_done", int'(done), 1);
    wait_to(124);
    chk("t2_ena_cnt", ena_cnt, 30);
    chk("t2_pdone", int'(periods_done), 1);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: continuous run, abort at cycle 95, restart at 97.
    push_ev(0, 31); push_ev(0, 61); push_ev(0, 91);
    run_start(0, 0);
    wait_to(95);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_tri_rst", int'(tri_rst), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_pdone", int'(periods_done), 3);
    chk("t3_ena_cnt", ena_cnt, 95);
    wait_to(97);
    chk("t3_sb_empty", sb.size(), 0);
    push_ev(0, 31); push_ev(1, 31);
    run_start(0, 1);
    chk("t3_pdone_clr", int'(periods_done), 0);
    wait_to(34);
    chk("t3b_pdone", int'(periods_done), 1);
    chk("t3b_sb_empty", sb.size(), 0);

    // 4: abort on the edge of the 2nd period completion; start during RUN ignored.
    push_ev(0, 31);
    run_start(0, 2);
    wait_to(10);
    prescale = 8'd5; n_periods = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(60);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_tri_rst", int'(tri_rst), 1);
    chk("t4_done", int'(done), 0);
    chk("t4_tick", int'(period_tick), 0);
    chk("t4_pdone", int'(periods_done), 1);
    wait_to(65);
    chk("t4_ena_cnt", ena_cnt, 60);
    chk("t4_pdone_hold", int'(periods_done), 1);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: inputs changed mid-RUN, then rst at cycle 40.
    run_start(1, 3);
    wait_to(10);
    prescale = 8'd0; n_periods = 8'd1;
    wait_to(40);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tri_rst", int'(tri_rst), 1);
    chk("t5_tri_ena", int'(tri_ena), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_tick", int'(period_tick), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_pdone", int'(periods_done), 0);
    chk("t5_ena_cnt", ena_cnt, 20);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle_ena", int'(tri_ena), 0);
    chk("t5_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
